// File: rtl/dcache_flush_seq_pkg.sv
// Data-cache geometry shared by the cache and its flush sequencer.
// Provides default set/way/tag/offset sizes; no ports.
package dcache_flush_seq_pkg;

    localparam int unsigned DC_NR_SETS = 256;
    localparam int unsigned DC_NR_WAYS = 8;
    localparam int unsigned DC_TAG_W   = 44;
    localparam int unsigned DC_OFF_W   = 4;

endpackage

// File: rtl/dcache_flush_seq_lzc.sv
// Leading/trailing zero counter (MODE=0: index of lowest set bit).
// Ports: in_i vector, cnt_o count/index, empty_o when in_i is all zero.
module dcache_flush_seq_lzc #(
    parameter int unsigned WIDTH = 8,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (!MODE) begin
            // scan downwards so the lowest set bit wins
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_W'(i);
            end
        end else begin
            // scan upwards so the highest set bit wins
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/dcache_flush_seq.sv
// Data-cache flush sequencer: walks all sets, writes back dirty lines,
// invalidates each set and pulses flush_ack_o when the cache is clean.
// Ports: clk_i/rst_ni; flush_i/flush_ack_o/busy_o controller side;
// tag_* tag-array request/response; wb_* write-back request to WB unit.
module dcache_flush_seq
    import dcache_flush_seq_pkg::*;
#(
    parameter int unsigned NR_SETS = DC_NR_SETS,
    parameter int unsigned NR_WAYS = DC_NR_WAYS,
    parameter int unsigned TAG_W   = DC_TAG_W,
    parameter int unsigned OFF_W   = DC_OFF_W,
    parameter int unsigned PLEN    = TAG_W + $clog2(NR_SETS) + OFF_W,
    localparam int unsigned IDX_W  = $clog2(NR_SETS),
    localparam int unsigned WAY_W  = $clog2(NR_WAYS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     flush_ack_o,
    output logic                     busy_o,
    output logic                     tag_req_o,
    output logic                     tag_we_o,
    output logic [IDX_W-1:0]         tag_idx_o,
    input  logic                     tag_gnt_i,
    input  logic                     tag_rvalid_i,
    input  logic [NR_WAYS*TAG_W-1:0] tag_rdata_i,
    input  logic [NR_WAYS-1:0]       valid_i,
    input  logic [NR_WAYS-1:0]       dirty_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [PLEN-1:0]          wb_addr_o,
    output logic [WAY_W-1:0]         wb_way_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WB,
        S_INV,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NR_WAYS-1:0]             pend_q, pend_d;
    logic [NR_WAYS-1:0][TAG_W-1:0]  tags_q, tags_d;
    logic                           armed_q, armed_d;

    logic                           ack_q;
    logic                           busy_q;
    logic                           tag_req_q;
    logic                           tag_we_q;
    logic [IDX_W-1:0]               tag_idx_q;
    logic                           wb_valid_q;
    logic [PLEN-1:0]                wb_addr_q;
    logic [WAY_W-1:0]               wb_way_q;

    logic [WAY_W-1:0]               way_d;
    logic                           pend_empty;
    logic                           last_set;

    assign last_set = (idx_q == IDX_W'(NR_SETS - 1));

    // Pending dirty ways and captured tags; kept apart from the state
    // logic so the find-first result feeds forward without a loop.
    always_comb begin
        pend_d = pend_q;
        tags_d = tags_q;
        if (state_q == S_WAIT && tag_rvalid_i) begin
            tags_d = tag_rdata_i;
            pend_d = valid_i & dirty_i;
        end else if (state_q == S_WB && wb_ready_i) begin
            pend_d = pend_q & ~(NR_WAYS'(1) << wb_way_q);
        end
    end

    dcache_flush_seq_lzc #(
        .WIDTH (NR_WAYS),
        .MODE  (1'b0)
    ) i_lzc (
        .in_i    (pend_d),
        .cnt_o   (way_d),
        .empty_o (pend_empty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        // the controller keeps flush_i high one cycle past the ack,
        // so only a low level re-enables a new walk
        if (!flush_i) armed_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (flush_i && armed_q) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end
            end
            S_READ: begin
                if (tag_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tag_rvalid_i) state_d = pend_empty ? S_INV : S_WB;
            end
            S_WB: begin
                if (wb_ready_i) state_d = pend_empty ? S_INV : S_WB;
            end
            S_INV: begin
                if (tag_gnt_i) begin
                    if (last_set) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = S_READ;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                armed_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every output is
    // a flop and matches the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pend_q     <= '0;
            tags_q     <= '0;
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            tag_req_q  <= 1'b0;
            tag_we_q   <= 1'b0;
            tag_idx_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_way_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            tags_q     <= tags_d;
            armed_q    <= armed_d;
            ack_q      <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            tag_req_q  <= (state_d == S_READ) || (state_d == S_INV);
            tag_we_q   <= (state_d == S_INV);
            tag_idx_q  <= idx_d;
            wb_valid_q <= (state_d == S_WB);
            if (state_d == S_WB) begin
                wb_way_q  <= way_d;
                wb_addr_q <= PLEN'({tags_d[way_d], idx_d, {OFF_W{1'b0}}});
            end else begin
                wb_way_q  <= '0;
                wb_addr_q <= '0;
            end
        end
    end

    assign flush_ack_o = ack_q;
    assign busy_o      = busy_q;
    assign tag_req_o   = tag_req_q;
    assign tag_we_o    = tag_we_q;
    assign tag_idx_o   = tag_idx_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_way_o    = wb_way_q;

endmodule
